// File: rtl/dog_rd_agen.sv
// Read-address generator for the separable DoG filter: a row-major horizontal pass over ram0,
// then a column-wise vertical pass, each line extended by PAD border pixels.
module dog_rd_agen #(
    parameter int unsigned XW  = 8,
    parameter int unsigned YW  = 8,
    parameter int unsigned PAD = 3,
    parameter int unsigned NCH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [1:0]               mode_i,
    input  logic [1:0]               pass_en_i,
    input  logic                     rd_ready_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     h_rd_valid_o,
    output logic [XW+YW-1:0]         h_rd_addr_o,
    output logic [NCH-1:0]           v_rd_valid_o,
    output logic [NCH*(XW+YW)-1:0]   v_rd_addr_o,
    output logic                     pad_zero_o,
    output logic                     line_end_o,
    output logic                     pass_last_o
);

    localparam int unsigned AW     = XW + YW;
    localparam int unsigned MW     = (XW > YW) ? XW : YW;
    localparam int unsigned CW     = MW + 2;
    localparam int          Width  = 1 << XW;
    localparam int          Height = 1 << YW;

    typedef logic signed [CW-1:0] idx_t;

    localparam idx_t          IMin   = idx_t'(-int'(PAD));
    localparam idx_t          WLast  = idx_t'(Width - 1);
    localparam idx_t          HLast  = idx_t'(Height - 1);
    localparam idx_t          HIMax  = idx_t'(Width - 1 + int'(PAD));
    localparam idx_t          VIMax  = idx_t'(Height - 1 + int'(PAD));
    localparam logic [MW-1:0] HLLast = MW'(Height - 1);
    localparam logic [MW-1:0] VLLast = MW'(Width - 1);

    typedef enum logic [1:0] {StIdle, StHrun, StVrun, StFin} state_e;

    // Border resolution happens at full signed width; callers truncate afterwards.
    function automatic idx_t map_idx(input idx_t i, input idx_t last, input logic [1:0] md);
        idx_t r;
        r = i;
        if (i[CW-1]) begin
            r = (md == 2'd1 || md == 2'd2) ? '0 : -i;
        end else if (i > last) begin
            if (md == 2'd1)      r = last;
            else if (md == 2'd2) r = '0;
            else                 r = (last <<< 1) - i;
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    idx_t            i_q, i_d;
    logic [MW-1:0]   l_q, l_d;
    logic [1:0]      mode_q, mode_d;
    logic [1:0]      pen_q, pen_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            h_valid_q, h_valid_d;
    logic            v_valid_q, v_valid_d;
    logic [AW-1:0]   h_addr_q, h_addr_d;
    logic [AW-1:0]   v_addr_q, v_addr_d;
    logic            pad_zero_q, pad_zero_d;
    logic            line_end_q, line_end_d;
    logic            pass_last_q, pass_last_d;

    logic            accept;
    idx_t            last;
    idx_t            mapped;
    logic            out_of_range;
    logic            unused_mapped;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        l_d     = l_q;
        mode_d  = mode_q;
        pen_d   = pen_q;
        accept  = (h_valid_q | v_valid_q) & rd_ready_i;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mode_d = mode_i;
                    pen_d  = pass_en_i;
                    i_d    = IMin;
                    l_d    = '0;
                    if (pass_en_i[0])      state_d = StHrun;
                    else if (pass_en_i[1]) state_d = StVrun;
                    else                   state_d = StFin;
                end
            end
            StHrun: begin
                if (accept) begin
                    if (i_q == HIMax) begin
                        i_d = IMin;
                        if (l_q == HLLast) begin
                            l_d     = '0;
                            state_d = pen_q[1] ? StVrun : StFin;
                        end else begin
                            l_d = l_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StVrun: begin
                if (accept) begin
                    if (i_q == VIMax) begin
                        i_d = IMin;
                        if (l_q == VLLast) begin
                            l_d     = '0;
                            state_d = StFin;
                        end else begin
                            l_d = l_q + 1'b1;
                        end
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
            end
            StFin: begin
                // A run with no passes enters here straight from idle and needs a second cycle.
                state_d = done_q ? StIdle : StFin;
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StHrun) || (state_d == StVrun);
        done_d = 1'b0;
        if (state_d == StFin) begin
            done_d = (state_q != StIdle);
            busy_d = !done_d;
        end

        h_valid_d    = (state_d == StHrun);
        v_valid_d    = (state_d == StVrun);
        last         = h_valid_d ? WLast : HLast;
        mapped       = map_idx(i_d, last, mode_d);
        out_of_range = i_d[CW-1] || (i_d > last);
        pad_zero_d   = (h_valid_d || v_valid_d) && (mode_d == 2'd2) && out_of_range;
        h_addr_d     = h_valid_d ? {l_d[YW-1:0], mapped[XW-1:0]} : '0;
        v_addr_d     = v_valid_d ? {mapped[YW-1:0], l_d[XW-1:0]} : '0;
        line_end_d   = h_valid_d ? (i_d == HIMax) : (v_valid_d ? (i_d == VIMax) : 1'b0);
        pass_last_d  = line_end_d && (h_valid_d ? (l_d == HLLast) : (l_d == VLLast));
    end

    assign unused_mapped = ^mapped;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            i_q         <= '0;
            l_q         <= '0;
            mode_q      <= '0;
            pen_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            h_valid_q   <= 1'b0;
            v_valid_q   <= 1'b0;
            h_addr_q    <= '0;
            v_addr_q    <= '0;
            pad_zero_q  <= 1'b0;
            line_end_q  <= 1'b0;
            pass_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            l_q         <= l_d;
            mode_q      <= mode_d;
            pen_q       <= pen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            h_valid_q   <= h_valid_d;
            v_valid_q   <= v_valid_d;
            h_addr_q    <= h_addr_d;
            v_addr_q    <= v_addr_d;
            pad_zero_q  <= pad_zero_d;
            line_end_q  <= line_end_d;
            pass_last_q <= pass_last_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign h_rd_valid_o = h_valid_q;
    assign h_rd_addr_o  = h_addr_q;
    assign v_rd_valid_o = {NCH{v_valid_q}};
    assign v_rd_addr_o  = {NCH{v_addr_q}};
    assign pad_zero_o   = pad_zero_q;
    assign line_end_o   = line_end_q;
    assign pass_last_o  = pass_last_q;

endmodule

// File: tb/tb_dog_rd_agen.sv
// Bench for dog_rd_agen: default-size instance for address tables, small instance for full-run
// scoreboarding with stalls, pass selection and done timing.
module tb_dog_rd_agen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, rd_ready;
    logic [1:0] mode, pen;

    logic        a_busy, a_done, a_hv, a_pz, a_le, a_pl;
    logic [15:0] a_ha;
    logic [1:0]  a_vv;
    logic [31:0] a_va;

    logic        b_busy, b_done, b_hv, b_pz, b_le, b_pl;
    logic [6:0]  b_ha;
    logic [1:0]  b_vv;
    logic [13:0] b_va;

    dog_rd_agen u_dut_a (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .pass_en_i(pen),
        .rd_ready_i(rd_ready), .busy_o(a_busy), .done_o(a_done), .h_rd_valid_o(a_hv),
        .h_rd_addr_o(a_ha), .v_rd_valid_o(a_vv), .v_rd_addr_o(a_va), .pad_zero_o(a_pz),
        .line_end_o(a_le), .pass_last_o(a_pl)
    );

    dog_rd_agen #(.XW(4), .YW(3), .PAD(2), .NCH(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start_i(start), .mode_i(mode), .pass_en_i(pen),
        .rd_ready_i(rd_ready), .busy_o(b_busy), .done_o(b_done), .h_rd_valid_o(b_hv),
        .h_rd_addr_o(b_ha), .v_rd_valid_o(b_vv), .v_rd_addr_o(b_va), .pad_zero_o(b_pz),
        .line_end_o(b_le), .pass_last_o(b_pl)
    );

    logic [55:0] a_all;
    logic [26:0] b_cur;
    assign a_all = {a_busy, a_done, a_hv, a_vv, a_ha, a_va, a_pz, a_le, a_pl};
    assign b_cur = {b_hv, b_vv, b_ha, b_va, b_pz, b_le, b_pl};

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        rd_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [1:0] md, input logic [1:0] pe);
        start = 1'b1;
        mode  = md;
        pen   = pe;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic int bmap(input int i, input int n, input int md);
        if (i >= 0 && i < n) return i;
        if (md == 1)         return (i < 0) ? 0 : n - 1;
        if (md == 2)         return 0;
        return (i < 0) ? -i : 2 * (n - 1) - i;
    endfunction

    typedef struct packed {
        logic       h;
        logic [6:0] a;
        logic       pz;
        logic       le;
        logic       pl;
    } bt_t;

    // Full run on the small instance; every observed beat is checked against a loop-built list.
    task automatic run_b(input logic [1:0] md, input logic [1:0] pe, input int stall_pct,
                         input bit extras);
        bt_t         exp_q[$];
        bt_t         e;
        logic [26:0] snap, ev;
        bit          held, valid;
        int          idx, cyc, a;
        logic        z;
        exp_q.delete();
        if (pe[0]) begin
            for (int l = 0; l < 8; l++) begin
                for (int i = -2; i <= 17; i++) begin
                    a = l * 16 + bmap(i, 16, md);
                    z = (md == 2) && (i < 0 || i > 15);
                    exp_q.push_back('{1'b1, 7'(a), z, i == 17, (i == 17) && (l == 7)});
                end
            end
        end
        if (pe[1]) begin
            for (int l = 0; l < 16; l++) begin
                for (int i = -2; i <= 9; i++) begin
                    a = bmap(i, 8, md) * 16 + l;
                    z = (md == 2) && (i < 0 || i > 7);
                    exp_q.push_back('{1'b0, 7'(a), z, i == 9, (i == 9) && (l == 15)});
                end
            end
        end
        do_reset();
        pulse_start(md, pe);
        cyc  = 1;
        idx  = 0;
        held = 1'b0;
        snap = '0;
        while (cyc < 3000) begin
            if (cyc == 1) chk($sformatf("busy after start md%0d pe%0d", md, pe), b_busy, 1);
            if (held) chk($sformatf("stall hold beat %0d", idx), b_cur, snap);
            if (b_done) break;
            valid = b_hv || (|b_vv);
            if (valid) begin
                if (idx < exp_q.size()) begin
                    e  = exp_q[idx];
                    ev = e.h ? {1'b1, 2'b00, e.a, 14'd0, e.pz, e.le, e.pl}
                             : {1'b0, 2'b11, 7'd0, e.a, e.a, e.pz, e.le, e.pl};
                    chk($sformatf("md%0d pe%0d beat %0d", md, pe, idx), b_cur, ev);
                end else begin
                    fail_now($sformatf("extra beat %0d md%0d pe%0d", idx, md, pe));
                end
            end else begin
                chk($sformatf("idle outputs cyc %0d", cyc), b_cur, 0);
            end
            rd_ready = ($urandom_range(99) >= stall_pct);
            held     = valid && !rd_ready;
            snap     = b_cur;
            if (valid && rd_ready) idx++;
            start = extras && (cyc == 20);
            if (extras && cyc == 20) mode = md ^ 2'b10;
            @(negedge clk);
            cyc++;
        end
        if (!b_done) fail_now($sformatf("done timeout md%0d pe%0d", md, pe));
        chk($sformatf("beat count md%0d pe%0d", md, pe), idx, exp_q.size());
        chk("busy low at done", b_busy, 0);
        if (stall_pct == 0)
            chk($sformatf("done cycle pe%0d", pe), cyc, (exp_q.size() == 0) ? 2 : exp_q.size() + 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start on done ignored", {b_busy, b_hv, b_vv, b_done}, 0);
    endtask

    typedef struct {
        logic [1:0]  md;
        int          beat;
        logic [15:0] addr;
        logic        pz;
        logic        le;
    } vec_t;

    vec_t vecs[21];

    initial begin
        int b, guard;
        bit saw;
        vecs[0]  = '{2'd0, 0,    16'h0003, 1'b0, 1'b0};
        vecs[1]  = '{2'd0, 1,    16'h0002, 1'b0, 1'b0};
        vecs[2]  = '{2'd0, 3,    16'h0000, 1'b0, 1'b0};
        vecs[3]  = '{2'd0, 4,    16'h0001, 1'b0, 1'b0};
        vecs[4]  = '{2'd0, 259,  16'h00FE, 1'b0, 1'b0};
        vecs[5]  = '{2'd0, 260,  16'h00FD, 1'b0, 1'b0};
        vecs[6]  = '{2'd0, 261,  16'h00FC, 1'b0, 1'b1};
        vecs[7]  = '{2'd0, 262,  16'h0103, 1'b0, 1'b0};
        vecs[8]  = '{2'd1, 1310, 16'h0500, 1'b0, 1'b0};
        vecs[9]  = '{2'd1, 1312, 16'h0500, 1'b0, 1'b0};
        vecs[10] = '{2'd1, 1313, 16'h0500, 1'b0, 1'b0};
        vecs[11] = '{2'd1, 1314, 16'h0501, 1'b0, 1'b0};
        vecs[12] = '{2'd1, 1568, 16'h05FF, 1'b0, 1'b0};
        vecs[13] = '{2'd1, 1571, 16'h05FF, 1'b0, 1'b1};
        vecs[14] = '{2'd2, 0,    16'h0000, 1'b1, 1'b0};
        vecs[15] = '{2'd2, 2,    16'h0000, 1'b1, 1'b0};
        vecs[16] = '{2'd2, 3,    16'h0000, 1'b0, 1'b0};
        vecs[17] = '{2'd2, 4,    16'h0001, 1'b0, 1'b0};
        vecs[18] = '{2'd2, 261,  16'h0000, 1'b1, 1'b1};
        vecs[19] = '{2'd2, 262,  16'h0100, 1'b1, 1'b0};
        vecs[20] = '{2'd3, 0,    16'h0003, 1'b0, 1'b0};

        mode = 2'd0;
        pen  = 2'd3;
        do_reset();
        chk("reset state a", a_all, 0);
        chk("reset state b", {b_busy, b_done, b_cur}, 0);

        for (int v = 0; v < 21; v++) begin
            do_reset();
            pulse_start(vecs[v].md, 2'd3);
            b     = 0;
            guard = 0;
            while (b < vecs[v].beat && guard < 5000) begin
                @(negedge clk);
                if (a_hv) b++;
                guard++;
            end
            if (b != vecs[v].beat) fail_now($sformatf("vec %0d beat timeout", v));
            chk($sformatf("vec %0d md%0d beat %0d", v, vecs[v].md, vecs[v].beat),
                {a_hv, a_vv, a_ha, a_pz, a_le}, {1'b1, 2'b00, vecs[v].addr, vecs[v].pz, vecs[v].le});
        end

        run_b(2'd0, 2'd3, 0, 1'b1);
        run_b(2'd1, 2'd3, 30, 1'b0);
        run_b(2'd2, 2'd3, 30, 1'b0);
        run_b(2'd0, 2'd2, 30, 1'b0);
        run_b(2'd2, 2'd1, 0, 1'b0);
        run_b(2'd3, 2'd3, 30, 1'b0);
        run_b(2'd0, 2'd0, 0, 1'b0);

        // Vertical mirror just past the bottom row of the small image folds back to row 6.
        do_reset();
        pulse_start(2'd0, 2'd2);
        repeat (10) @(negedge clk);
        chk("v mirror i=8", {b_hv, b_vv, b_va}, {1'b0, 2'b11, 7'h60, 7'h60});

        // Asynchronous reset in the middle of the horizontal pass.
        do_reset();
        pulse_start(2'd0, 2'd3);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async reset clears outputs", a_all, 0);
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (a_done || a_hv || b_done) saw = 1'b1;
        end
        chk("no done after abort", saw, 0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(2'd0, 2'd3);
        chk("restart first beat", {a_hv, a_ha}, {1'b1, 16'h0003});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dog_rd_agen.md
# dog_rd_agen

Parametrised read-address generator for the difference-of-Gaussian separable filter datapath. It scans a 2^XW x 2^YW image buffer in two passes: a horizontal pass reading ram0 row-major, then a vertical pass reading the intermediate buffer column-wise on NCH parallel ports. Each scan line is extended by PAD pixels on both sides using a run-time-selectable border mode. A valid/ready handshake lets the downstream filter pipeline stall the scan.

## Interface
- XW, 8, log2 image width W
- YW, 8, log2 image height H
- PAD, 3, border pixels added at each end of a line; legal range 1..min(W,H)-2
- NCH, 2, number of vertical-pass read ports; all carry identical valid/address
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle start pulse; ignored while busy
- mode  in  2  border mode, sampled on accepted start: 0 mirror, 1 replicate, 2 zero, 3 reserved (treated as mirror)
- pass_en  in  2  sampled on accepted start: bit0 enables the horizontal pass, bit1 enables the vertical pass
- rd_ready  in  1  downstream accepts the current beat
- busy  out  1  high from the cycle after an accepted start until the cycle done is high
- done  out  1  one-cycle pulse after the last beat is accepted
- h_rd_valid  out  1  horizontal-pass beat valid
- h_rd_addr  out  XW+YW  horizontal address {row[YW-1:0], col[XW-1:0]}
- v_rd_valid  out  NCH  vertical-pass beat valid, replicated
- v_rd_addr  out  NCH*(XW+YW)  vertical address {row, col}, replicated per port
- pad_zero  out  1  current beat is a zero-pad pixel; downstream substitutes 0
- line_end  out  1  current beat is the last beat of a line
- pass_last  out  1  current beat is the last beat of the current pass

## Operation
- FSM states: IDLE, HRUN, VRUN, FIN.
  - IDLE + start: go to HRUN if pass_en[0]; else VRUN if pass_en[1]; else FIN.
  - HRUN, last beat accepted: go to VRUN if pass_en[1]; else FIN.
  - VRUN, last beat accepted: go to FIN.
  - FIN lasts one cycle, pulses done, then returns to IDLE.
- Counters:
  - Signed inner counter i runs -PAD..N-1+PAD, where N=W in HRUN and N=H in VRUN.
  - Line counter l runs 0..L-1, where L=H in HRUN and L=W in VRUN.
  - i advances only on an accepted beat (valid & rd_ready). It wraps to -PAD after N-1+PAD, and l increments on that wrap.
- Border mapping m(i), with in-range i mapping to i:
  - mirror, no edge repeat: i<0 gives -i; i>N-1 gives 2(N-1)-i.
  - replicate: i<0 gives 0; i>N-1 gives N-1.
  - zero: out-of-range i gives address field 0 and pad_zero=1.
- Address per pass:
  - HRUN: h_rd_addr={l, m(i)}.
  - VRUN: v_rd_addr={m(i), l}; the column is l.
  - The inactive pass's valid is 0 and its address is 0.
- Beats per pass:
  - HRUN: H*(W+2PAD).
  - VRUN: W*(H+2PAD).
- Arithmetic width: the inner counter is max(XW,YW)+2 bits signed. The mapped result is truncated to XW or YW bits only after range resolution.
- mode and pass_en are held in internal registers for the whole run. Input changes during a run have no effect.
- Reset mid-run aborts immediately. All state returns to IDLE and no done pulse is issued.

## Timing
- Reset values: busy 0, done 0, all valids 0, all addresses 0, pad_zero 0, line_end 0, pass_last 0.
- All outputs are registered.
- The first beat appears 1 cycle after the accepted start: start sampled at edge k gives valid high at edge k+1.
- Handshake: while valid=1 and rd_ready=0, the address and all flags hold stable. A beat is accepted on an edge where valid & rd_ready.
- With rd_ready held high, one beat is issued per cycle. There are no bubbles within a pass or at line wraps.
- HRUN to VRUN: the first V beat appears in the cycle after the last H beat is accepted, so there is zero idle cycles between passes.
- done is high in the cycle after the last accepted beat; busy drops in that same cycle.
- start in the same cycle as done is ignored. A new start is accepted from IDLE in the next cycle.
- If pass_en=0, start gives done 2 cycles later and no beats are issued.

## Test plan
- Defaults, mode 0, pass_en=3, rd_ready=1:
  - The first H addresses are 0x0003, 0x0002, 0x0001, 0x0000.
  - Row 0 ends with 0x00FE, 0x00FD, 0x00FC, with line_end on 0x00FC.
  - There are 67072 H beats, then 67072 V beats; the first V beat is 0x0300.
  - done occurs exactly 134145 cycles after start.
- Mode 1:
  - Row 5 yields 0x0500 three times, then 0x0500..0x05FF, then 0x05FF three times.
- Mode 2:
  - The first 3 beats of each line have address field 0 with pad_zero=1.
  - pad_zero is 0 on in-range beats.
- Random rd_ready stalls (30% low), checked by a scoreboard:
  - The beat sequence is identical to the no-stall run.
  - Address and flags are stable while stalled, with no lost or duplicated beats.
- Parameter sweep with XW=4, YW=3, PAD=2:
  - There are 8*20 H beats and 16*12 V beats.
  - V mirror at i=8 gives row 6.
  - pass_en=2 gives V beats only; pass_en=0 gives done with no valids.
- Edge-case timing:
  - start while busy is ignored.
  - Changing mode mid-run has no effect.
  - rst_n asserted mid-HRUN clears all outputs asynchronously, with no done pulse.
  - After release, a restart begins again at 0x0003.
